// File: rtl/regfile_dump.sv
// regfile_dump: freezes the pipeline, sweeps every architectural register
// through one regfile read port and streams (index, value) pairs out over a
// valid/ready channel.
// Build option: REGFILE_DUMP_SKIP_X0_EN starts the sweep at index 1 so x0 is
// never read. Everything else (FSM, ports, last-index compare) is identical.
module regfile_dump #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     stall_req,
  input  logic                     stall_ack,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_index,
  output logic                     busy,
  output logic                     done
);

  // One extra counter bit so the last-index compare never depends on wrap.
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'((2 ** ADDRESS_WIDTH) - 1);
`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam logic [CW-1:0] FIRST = CW'(1);
`else
  localparam logic [CW-1:0] FIRST = CW'(0);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] idx, idx_nxt;
  logic          cap;

  // State, index counter and the output word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cap) begin
        out_data  <= rd_data;
        out_index <= idx[ADDRESS_WIDTH-1:0];
      end
    end
  end

  // Next-state, counter update and Moore outputs.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cap       = 1'b0;
    stall_req = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_nxt   = FIRST;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        stall_req = 1'b1;
        if (stall_ack) state_nxt = S_READ;
      end
      S_READ: begin
        stall_req = 1'b1;
        rd_addr   = idx[ADDRESS_WIDTH-1:0];
        // Losing the ack means the port mux may not be ours; wait it out.
        if (stall_ack) begin
          cap       = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        stall_req = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx == LAST) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + CW'(1);
            state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a small regfile model answers rd_addr, expected
// (index, value) words are queued when a sweep is launched and popped as the
// sink accepts each word.
module tb_regfile_dump;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 2 ** AW;
`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall_req;
  logic          stall_ack = 1'b1;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NREG];
  assign rd_data = regs[rd_addr];

  regfile_dump #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stall_req(stall_req), .stall_ack(stall_ack),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [63:0] sb [$];
  logic        mon_hold = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [AW-1:0] hold_idx = '0;

  function automatic logic [DW-1:0] exp_val(input int k);
    return (k == 0) ? '0 : DW'(32'h1000 + k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe the channel just before the edge, then advance one clock.
  task automatic tick();
    if (mon_hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_word", {27'd0, out_index, out_data}, {27'd0, hold_idx, hold_data});
    end
    mon_hold  = out_valid && !out_ready;
    hold_data = out_data;
    hold_idx  = out_index;
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_extra got=%0h exp=none", {out_index, out_data});
      end
      if (sb.size() != 0) chk("word", {27'd0, out_index, out_data}, sb.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // d: cycles stall_ack is held low after start; rnd: random sink ready;
  // xs: pulse start again mid-sweep (must be ignored).
  task automatic do_sweep(input int d, input bit rnd, input bit xs);
    int s;
    int n;
    int w;
    int dc0;
    sb.delete();
    for (int k = FIRST; k < NREG; k++) sb.push_back({27'd0, AW'(k), exp_val(k)});
    w   = NREG - FIRST;
    dc0 = done_cnt;
    stall_ack = (d == 0);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    chk("stall_req_start", 64'(stall_req), 64'd1);
    chk("busy_start", 64'(busy), 64'd1);
    for (int k = 0; k < d; k++) begin
      chk("ack_wait_req", 64'(stall_req), 64'd1);
      chk("ack_wait_addr", 64'(rd_addr), 64'd0);
      chk("ack_wait_valid", 64'(out_valid), 64'd0);
      tick();
    end
    stall_ack = 1'b1;
    n = 0;
    while (done_cnt == dc0 && n < 2000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      start = (xs && cyc == s + 10);
      tick();
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", 64'(done_cnt - dc0), 64'd1);
    // Sequence: REQ, d wait cycles, READ+SEND per word, then DONE.
    if (!rnd) chk("done_cycle", 64'(done_cyc - s), 64'(d + 2 * w + 1));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("single_done", 64'(done_cnt - dc0), 64'd1);
  endtask

  initial begin
    bit found;
    int dc;
    for (int k = 0; k < NREG; k++) regs[k] = exp_val(k);

    // Reset state.
    tick();
    tick();
    chk("rst_stall_req", 64'(stall_req), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // Plain sweep, ack and ready always high.
    do_sweep(0, 1'b0, 1'b0);
    // Pipeline slow to freeze.
    do_sweep(5, 1'b0, 1'b0);
    // Back-pressured sink.
    do_sweep(0, 1'b1, 1'b0);
    // Stray start while busy.
    do_sweep(0, 1'b0, 1'b1);

    // Reset while SEND presents index 12.
    sb.delete();
    for (int k = FIRST; k < NREG; k++) sb.push_back({27'd0, AW'(k), exp_val(k)});
    dc = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (out_valid && out_index == AW'(12)) found = 1'b1;
      else tick();
    end
    chk("reached_idx12", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_stall_req", 64'(stall_req), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_data", 64'(out_data), 64'd0);
    chk("abort_out_index", 64'(out_index), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    sb.delete();
    mon_hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
    // Fresh start sweeps from the first index again.
    do_sweep(0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
